sid_voice_sched: RTL and testbench

- Time-multiplexes the shared voice datapath (waveform select, waveform/envelope DACs, voice DCA; one result per active cycle, 1-cycle output latency) across NUM_VOICES voices: 2 SID chips × 3 voices.
- Per round, it issues one active cycle per voice in fixed slot order. It also drives the voice index to the upstream voice_i/model mux.
- It captures each delayed voice_o/osc_o into per-voice holding registers.
- It generates a round-aligned millisecond tick for the waveform-0 fade logic.

---
 rtl/sid_voice_sched.sv | 205 ++++++++++++++++++++
 tb/tb_sid_voice_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_sched.sv
// sid_voice_sched: shares one voice datapath across 2 SID chips x 3 voices.
// Each round gives every voice one active datapath cycle, in fixed slot order.
// Each delayed result is captured into a per-voice holding register.
// A millisecond tick is held for a whole round, so every voice sees the same tick.
// Optional build macro SID_VOICE_SCHED_OSC3_EN: captures OSC3 of voices 2 and 5
// into osc3_out. Without it, osc3_out is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one active datapath cycle per voice, slot 0..NUM_VOICES-1
// FLUSH | result of the last slot arrives; a start here chains the next round

module sid_voice_sched #(
   parameter int NUM_VOICES = 6,
   parameter int CLK_PER_MS = 24000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun,
   output logic                     active,
   output logic [2:0]               slot,
   output logic                     tick_ms,
   input  logic [21:0]              voice_o,
   input  logic [7:0]               osc_o,
   output logic [22*NUM_VOICES-1:0] voice_out,
   output logic [15:0]              osc3_out
);

   localparam int              MS_W      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [2:0]      LAST_SLOT = 3'(NUM_VOICES - 1);
   localparam logic [MS_W-1:0] MS_LAST   = MS_W'(CLK_PER_MS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    overrun_q, overrun_d;
   logic                    active_q, active_d;
   logic [2:0]              slot_q, slot_d;
   logic                    tick_ms_q, tick_ms_d;
   logic                    tick_round_q, tick_round_d;
   logic                    tick_pending_q, tick_pending_d;
   logic [MS_W-1:0]         ms_cnt_q, ms_cnt_d;
   logic                    cap_vld_q, cap_vld_d;
   logic [2:0]              cap_idx_q, cap_idx_d;
   logic [22*NUM_VOICES-1:0] voice_out_q, voice_out_d;
   logic                    accept;
   logic                    ms_wrap;

   // Next-state logic: slot sequencing, start acceptance, ms tick, and capture pipeline
   always_comb begin
      ms_wrap        = (ms_cnt_q == MS_LAST);
      ms_cnt_d       = ms_wrap ? '0 : ms_cnt_q + 1'b1;
      state_d        = state_q;
      slot_d         = slot_q;
      overrun_d      = overrun_q;
      tick_round_d   = tick_round_q;
      tick_pending_d = tick_pending_q;
      accept         = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
               slot_d  = 3'd0;
            end
         end
         RUN: begin
            // The datapath delay lines cannot tolerate a stall, so a start here is lost
            if (start) begin
               overrun_d = 1'b1;
            end
            if (slot_q == LAST_SLOT) begin
               state_d = FLUSH;
               slot_d  = 3'd0;
            end else begin
               slot_d = slot_q + 3'd1;
            end
         end
         FLUSH: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
               slot_d  = 3'd0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            slot_d  = 3'd0;
         end
      endcase

      // A wrap in the accept cycle belongs to the round that starts now
      if (accept) begin
         tick_round_d   = tick_pending_q | ms_wrap;
         tick_pending_d = 1'b0;
      end else if (ms_wrap) begin
         tick_pending_d = 1'b1;
      end

      active_d  = (state_d == RUN);
      busy_d    = (state_d != IDLE);
      tick_ms_d = tick_round_d & active_d;

      // Results lag the active cycle by one, so capture uses the previous slot
      cap_vld_d = active_q;
      cap_idx_d = slot_q;
      done_d    = cap_vld_q & (cap_idx_q == LAST_SLOT);
   end

   // Per-voice holding registers: only the arriving slot's entry changes
   always_comb begin
      voice_out_d = voice_out_q;
      if (cap_vld_q) begin
         for (int k = 0; k < NUM_VOICES; k++) begin
            if (cap_idx_q == 3'(k)) begin
               voice_out_d[22*k +: 22] = voice_o;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
         active_q       <= 1'b0;
         slot_q         <= 3'd0;
         tick_ms_q      <= 1'b0;
         tick_round_q   <= 1'b0;
         tick_pending_q <= 1'b0;
         ms_cnt_q       <= '0;
         cap_vld_q      <= 1'b0;
         cap_idx_q      <= 3'd0;
         voice_out_q    <= '0;
      end else begin
         state_q        <= state_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         overrun_q      <= overrun_d;
         active_q       <= active_d;
         slot_q         <= slot_d;
         tick_ms_q      <= tick_ms_d;
         tick_round_q   <= tick_round_d;
         tick_pending_q <= tick_pending_d;
         ms_cnt_q       <= ms_cnt_d;
         cap_vld_q      <= cap_vld_d;
         cap_idx_q      <= cap_idx_d;
         voice_out_q    <= voice_out_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;
   assign active    = active_q;
   assign slot      = slot_q;
   assign tick_ms   = tick_ms_q;
   assign voice_out = voice_out_q;

`ifdef SID_VOICE_SCHED_OSC3_EN
   logic [15:0] osc3_q, osc3_d;

   // OSC3 of voice 2 (chip 0) and voice 5 (chip 1), on the same timing as voice_out
   always_comb begin
      osc3_d = osc3_q;
      if (cap_vld_q && (cap_idx_q == 3'd2)) begin
         osc3_d[7:0] = osc_o;
      end
      if (cap_vld_q && (cap_idx_q == 3'd5)) begin
         osc3_d[15:8] = osc_o;
      end
   end

   // OSC3 holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         osc3_q <= 16'h0000;
      end else begin
         osc3_q <= osc3_d;
      end
   end

   assign osc3_out = osc3_q;
`else
   logic unused_osc;
   assign unused_osc = ^osc_o;
   assign osc3_out   = 16'h0000;
`endif

endmodule

// File: tb/tb_sid_voice_sched.sv
// tb_sid_voice_sched: randomized bench for sid_voice_sched.
// A round-level reference model predicts every output cycle by cycle.
// A scoreboard checks the captured vector whenever done pulses.

module tb_sid_voice_sched;

   localparam int NV = 6;
   localparam int P  = 20;

   logic             clk     = 1'b0;
   logic             rst     = 1'b0;
   logic             start   = 1'b0;
   logic [21:0]      voice_o = '0;
   logic [7:0]       osc_o   = '0;
   logic             busy, done, overrun, active, tick_ms;
   logic [2:0]       slot;
   logic [22*NV-1:0] voice_out;
   logic [15:0]      osc3_out;

   sid_voice_sched #(.NUM_VOICES(NV), .CLK_PER_MS(P)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun),
      .active    (active),
      .slot      (slot),
      .tick_ms   (tick_ms),
      .voice_o   (voice_o),
      .osc_o     (osc_o),
      .voice_out (voice_out),
      .osc3_out  (osc3_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int                  t;
      bit                  tick;
      logic [NV-1:0][21:0] v;
      logic [NV-1:0][7:0]  o;
   } round_t;

   typedef struct {
      int                  due;
      logic [NV-1:0][21:0] v;
      logic [15:0]         osc;
   } exp_t;

   round_t rounds[$];
   exp_t   sb[$];

   bit                  armed      = 1'b0;
   bit                  ov_m       = 1'b0;
   int                  c0         = 0;
   int                  wraps_last = 0;
   int                  n_accept   = 0;
   logic [NV-1:0][21:0] cap_v      = '0;
   logic [15:0]         cap_o      = '0;

   task automatic check(input string name, input logic [131:0] act, input logic [131:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endtask

   // Number of ms-counter wraps in cycles c0..c since the last reset
   function automatic int wraps(input int c);
      return (c >= c0) ? (c - c0 + 1) / P : 0;
   endfunction

   // Reference model: check expected outputs for this cycle, then absorb this cycle's inputs
   always @(negedge clk) begin
      int       x, k;
      bit       e_act, e_busy, e_done, e_tick;
      logic [2:0] e_slot;
      round_t   r;
      exp_t     e;
      #1;
      x = cyc;
      while (rounds.size() > 0 && rounds[0].t + NV + 2 < x) void'(rounds.pop_front());
      e_act = 0; e_busy = 0; e_done = 0; e_tick = 0; e_slot = 3'd0;
      foreach (rounds[i]) begin
         if (x >= rounds[i].t + 1 && x <= rounds[i].t + NV) begin
            e_act  = 1;
            e_slot = 3'(x - rounds[i].t - 1);
            e_tick = rounds[i].tick;
         end
         if (x >= rounds[i].t + 1 && x <= rounds[i].t + NV + 1) e_busy = 1;
         if (x == rounds[i].t + NV + 2) e_done = 1;
      end
      if (armed) begin
         check("active",    132'(active),  132'(e_act));
         if (e_act) check("slot", 132'(slot), 132'(e_slot));
         check("busy",      132'(busy),    132'(e_busy));
         check("done",      132'(done),    132'(e_done));
         check("tick_ms",   132'(tick_ms), 132'(e_act & e_tick));
         check("overrun",   132'(overrun), 132'(ov_m));
         check("voice_out", voice_out,     cap_v);
         check("osc3_out",  132'(osc3_out), 132'(cap_o));
      end
      if (rst) begin
         armed      = 1'b1;
         rounds.delete();
         sb.delete();
         ov_m       = 1'b0;
         cap_v      = '0;
         cap_o      = '0;
         c0         = x + 1;
         wraps_last = 0;
      end else if (armed) begin
         foreach (rounds[i]) begin
            k = x - rounds[i].t - 2;
            if (k >= 0 && k < NV) begin
               cap_v[3'(k)] = rounds[i].v[3'(k)];
`ifdef SID_VOICE_SCHED_OSC3_EN
               if (k == 2) cap_o[7:0]  = rounds[i].o[3'(k)];
               if (k == 5) cap_o[15:8] = rounds[i].o[3'(k)];
`endif
            end
         end
         if (start) begin
            if (e_act) begin
               ov_m = 1'b1;
            end else begin
               r.t        = x;
               r.tick     = (wraps(x) > wraps_last);
               wraps_last = wraps(x);
               for (int j = 0; j < NV; j++) begin
                  r.v[3'(j)] = (n_accept == 0) ? 22'(22'h1000 + j) : 22'($urandom);
                  r.o[3'(j)] = 8'($urandom);
               end
               if (n_accept == 0) begin
                  r.o[3'd2] = 8'hA5;
                  r.o[3'd5] = 8'h5A;
               end
               n_accept++;
               rounds.push_back(r);
               e.due = x + NV + 2;
               e.v   = r.v;
`ifdef SID_VOICE_SCHED_OSC3_EN
               e.osc = {r.o[3'd5], r.o[3'd2]};
`else
               e.osc = 16'h0000;
`endif
               sb.push_back(e);
            end
         end
      end
   end

   // Scoreboard monitor: each done pulse retires one expected round
   always @(negedge clk) begin
      exp_t e2;
      if (armed && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected at cycle %0d: got done=1, expected no pending round", cyc);
         end else begin
            e2 = sb.pop_front();
            check("done_cycle",  132'(cyc),      132'(e2.due));
            check("round_voice", voice_out,      e2.v);
            check("round_osc3",  132'(osc3_out), 132'(e2.osc));
         end
      end
   end

   // Drive one cycle: control inputs plus the datapath result the model schedules
   task automatic step(input bit s, input bit r);
      int k;
      @(posedge clk);
      #1;
      start   = s;
      rst     = r;
      voice_o = 22'($urandom);
      osc_o   = 8'($urandom);
      foreach (rounds[i]) begin
         k = cyc - rounds[i].t - 2;
         if (k >= 0 && k < NV) begin
            voice_o = rounds[i].v[3'(k)];
            osc_o   = rounds[i].o[3'(k)];
         end
      end
   endtask

   task automatic idle_until(input int c);
      while (cyc < c - 1) step(1'b0, 1'b0);
   endtask

   task automatic pulse_at(input int c, input bit s, input bit r);
      idle_until(c);
      step(s, r);
   endtask

   initial begin
      repeat (3) step(1'b0, 1'b1);
      // single round, directed data
      pulse_at(10, 1'b1, 1'b0);
      // back-to-back round from FLUSH, then a dropped start in RUN
      pulse_at(40, 1'b1, 1'b0);
      pulse_at(47, 1'b1, 1'b0);
      pulse_at(50, 1'b1, 1'b0);
      pulse_at(70, 1'b0, 1'b1);
      // reset while slot 3 is active, then a normal round
      pulse_at(80, 1'b1, 1'b0);
      pulse_at(84, 1'b0, 1'b1);
      pulse_at(90, 1'b1, 1'b0);
      // rounds at the minimum period, to exercise the tick
      for (int i = 0; i < 40; i++) pulse_at(120 + 7 * i, 1'b1, 1'b0);
      // random starts and occasional resets
      idle_until(420);
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
      end
      repeat (15) step(1'b0, 1'b0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending rounds, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
